// File: rtl/ball_link_rx_if.sv
// ball_link_rx_if: serial line in, decoded ball state and error strobes out
interface ball_link_rx_if;
    logic       uart_rx;
    logic       ball_rx_valid;
    logic [9:0] ball_y_rx;
    logic [7:0] ball_vy_rx;
    logic       frame_err;
    logic       pkt_err;
    modport master (output uart_rx, input ball_rx_valid, input ball_y_rx, input ball_vy_rx, input frame_err, input pkt_err);
    modport slave (input uart_rx, output ball_rx_valid, output ball_y_rx, output ball_vy_rx, output frame_err, output pkt_err);
endinterface

// File: rtl/ball_link_rx.sv
// ball_link_rx: 8N1 receiver plus ball-handoff packet parser with checksum and inter-byte timeout
module ball_link_rx #(
    parameter int          CLKS_PER_BIT = 217,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 8680
) (
    input logic          clk_25MHZ,
    input logic          reset,
    ball_link_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bstate_t;
    typedef enum logic [2:0] {WAIT_SYNC, GET_YHI, GET_YLO, GET_VY, GET_CHK} pstate_t;

    logic [1:0]    sync;
    logic          rx;
    bstate_t       bs, bs_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          mid, half, byte_done, stop_fail;
    pstate_t       ps, ps_nx;
    logic [TW-1:0] idle_cnt;
    logic [1:0]    y_hi;
    logic [7:0]    y_lo, vy;
    logic          timeout, yhi_bad, chk_ok, good, bad;

    assign rx   = sync[1];
    assign mid  = cnt == MID;
    assign half = cnt == HALF;

    always_ff @(posedge clk_25MHZ or posedge reset)
        if (reset) sync <= 2'b11;
        else sync <= {sync[0], bus.uart_rx};

    always_ff @(posedge clk_25MHZ or posedge reset)
        if (reset) bs <= IDLE;
        else bs <= bs_nx;

    always_comb begin
        bs_nx = bs;
        case (bs)
            IDLE:    bs_nx = rx ? IDLE : START;
            START:   bs_nx = half ? (rx ? IDLE : DATA) : START;
            DATA:    bs_nx = (mid && bit_idx == 3'd7) ? STOP : DATA;
            STOP:    bs_nx = mid ? IDLE : STOP;
            default: bs_nx = IDLE;
        endcase
    end

    // Stop bit is judged at mid-bit; its second half is not waited for.
    always_comb begin
        byte_done = bs == STOP && mid && rx;
        stop_fail = bs == STOP && mid && !rx;
    end

    always_ff @(posedge clk_25MHZ or posedge reset)
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            cnt     <= (bs == IDLE || bs_nx != bs || (bs == DATA && mid)) ? '0 : cnt + 1'b1;
            bit_idx <= bs != DATA ? '0 : bit_idx + {2'b0, mid};
            if (bs == DATA && mid) shreg <= {rx, shreg[7:1]};
        end

    assign yhi_bad = shreg[7:2] != 6'd0;
    assign chk_ok  = shreg == ({6'd0, y_hi} ^ y_lo ^ vy);
    assign timeout = ps != WAIT_SYNC && !byte_done && idle_cnt == TMO_LAST;

    always_ff @(posedge clk_25MHZ or posedge reset)
        if (reset) ps <= WAIT_SYNC;
        else ps <= ps_nx;

    always_comb begin
        ps_nx = ps;
        if (stop_fail || timeout) ps_nx = WAIT_SYNC;
        else if (byte_done)
            case (ps)
                WAIT_SYNC: ps_nx = shreg == SYNC_BYTE ? GET_YHI : WAIT_SYNC;
                GET_YHI:   ps_nx = yhi_bad ? WAIT_SYNC : GET_YLO;
                GET_YLO:   ps_nx = GET_VY;
                GET_VY:    ps_nx = GET_CHK;
                default:   ps_nx = WAIT_SYNC;
            endcase
    end

    // A frame error masks any coincident packet error.
    always_comb begin
        good = byte_done && ps == GET_CHK && chk_ok;
        bad  = !stop_fail && (timeout || (byte_done && ((ps == GET_YHI && yhi_bad) || (ps == GET_CHK && !chk_ok))));
    end

    always_ff @(posedge clk_25MHZ or posedge reset)
        if (reset) begin
            idle_cnt          <= '0;
            y_hi              <= '0;
            y_lo              <= '0;
            vy                <= '0;
            bus.ball_rx_valid <= 1'b0;
            bus.pkt_err       <= 1'b0;
            bus.frame_err     <= 1'b0;
            bus.ball_y_rx     <= '0;
            bus.ball_vy_rx    <= '0;
        end else begin
            idle_cnt          <= (ps_nx == WAIT_SYNC || byte_done) ? '0 : idle_cnt + 1'b1;
            if (byte_done && ps == GET_YHI) y_hi <= shreg[1:0];
            if (byte_done && ps == GET_YLO) y_lo <= shreg;
            if (byte_done && ps == GET_VY) vy <= shreg;
            bus.ball_rx_valid <= good;
            bus.pkt_err       <= bad;
            bus.frame_err     <= stop_fail;
            if (good) begin
                bus.ball_y_rx  <= {y_hi, y_lo};
                bus.ball_vy_rx <= vy;
            end
        end
endmodule

// File: tb/tb_ball_link_rx.sv
// tb_ball_link_rx: randomized byte-stream stimulus with a packet-level model and an event scoreboard
module tb_ball_link_rx;
    localparam int         CPB  = 16;
    localparam int         TMO  = 640;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int EV_VALID = 0, EV_PKT = 1, EV_FRAME = 2;

    typedef struct {
        int         kind;
        logic [9:0] y;
        logic [7:0] vy;
    } ev_t;

    logic clk_25MHZ = 1'b0;
    logic reset = 1'b1;
    always #20 clk_25MHZ = ~clk_25MHZ;

    ball_link_rx_if bus();
    ball_link_rx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TMO)) dut (
        .clk_25MHZ(clk_25MHZ),
        .reset(reset),
        .bus(bus)
    );

    ev_t        sb[$];
    logic [7:0] pkt_q[$];
    logic [9:0] m_y = '0;
    logic [7:0] m_vy = '0;
    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void expect_ev(input int k);
        ev_t e;
        e.kind = k;
        e.y = m_y;
        e.vy = m_vy;
        sb.push_back(e);
    endfunction

    // Packet-level reference: bytes after a sync are collected and judged as a whole.
    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] hi, lo, v, c;
        if (pkt_q.size() == 0) begin
            if (b == SYNC) pkt_q.push_back(b);
        end else begin
            pkt_q.push_back(b);
            if (pkt_q.size() == 2 && b[7:2] != 6'd0) begin
                expect_ev(EV_PKT);
                pkt_q.delete();
            end else if (pkt_q.size() == 5) begin
                hi = pkt_q[1]; lo = pkt_q[2]; v = pkt_q[3]; c = pkt_q[4];
                if ((hi ^ lo ^ v) == c) begin
                    m_y = {hi[1:0], lo};
                    m_vy = v;
                    expect_ev(EV_VALID);
                end else expect_ev(EV_PKT);
                pkt_q.delete();
            end
        end
    endfunction

    function automatic void model_timeout();
        if (pkt_q.size() != 0) begin
            expect_ev(EV_PKT);
            pkt_q.delete();
        end
    endfunction

    task automatic observe(input int k);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=%0d required=none", k);
        end else begin
            e = sb.pop_front();
            check("event_kind", k, e.kind);
            check("ball_y_rx", bus.ball_y_rx, e.y);
            check("ball_vy_rx", bus.ball_vy_rx, e.vy);
        end
    endtask

    always @(negedge clk_25MHZ)
        if (!reset) begin
            if (bus.pkt_err || bus.frame_err) check("err_exclusive", bus.pkt_err & bus.frame_err, 0);
            if (bus.ball_rx_valid) observe(EV_VALID);
            if (bus.pkt_err) observe(EV_PKT);
            if (bus.frame_err) observe(EV_FRAME);
        end

    task automatic idle(input int n);
        bus.uart_rx = 1'b1;
        repeat (n) @(negedge clk_25MHZ);
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop, input int rst_bit);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.uart_rx = fr[i];
            if (i == rst_bit) begin
                repeat (5) @(negedge clk_25MHZ);
                #3 reset = 1'b1;
                #1;
                check("rst_y", bus.ball_y_rx, 0);
                check("rst_vy", bus.ball_vy_rx, 0);
                check("rst_strobes", {bus.ball_rx_valid, bus.pkt_err, bus.frame_err}, 0);
                repeat (CPB - 5) @(negedge clk_25MHZ);
            end else repeat (CPB) @(negedge clk_25MHZ);
        end
        if (rst_bit >= 0) reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_raw(b, 1'b1, -1);
        idle($urandom_range(0, 3));
    endtask

    task automatic send_pkt(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] v, input logic [7:0] c);
        send_byte(SYNC);
        send_byte(hi);
        send_byte(lo);
        send_byte(v);
        send_byte(c);
    endtask

    task automatic send_good(input logic [9:0] y, input logic [7:0] v);
        logic [7:0] hi;
        hi = {6'd0, y[9:8]};
        send_pkt(hi, y[7:0], v, hi ^ y[7:0] ^ v);
    endtask

    task automatic send_frame(input logic [7:0] b);
        expect_ev(EV_FRAME);
        pkt_q.delete();
        send_raw(b, 1'b0, -1);
        idle(32);
    endtask

    initial begin
        logic [9:0] ry;
        logic [7:0] rv, rh;
        bus.uart_rx = 1'b1;
        repeat (5) @(negedge clk_25MHZ);
        check("reset_valid", bus.ball_rx_valid, 0);
        check("reset_y", bus.ball_y_rx, 0);
        check("reset_vy", bus.ball_vy_rx, 0);
        check("reset_errs", {bus.pkt_err, bus.frame_err}, 0);
        reset = 1'b0;
        idle(20);

        send_pkt(8'h01, 8'h2C, 8'hFD, 8'hD0);
        idle(50);
        check("plan_y300", bus.ball_y_rx, 300);
        send_pkt(8'h01, 8'h2C, 8'hFD, 8'hD1);
        idle(50);
        foreach (pkt_q[i]) pkt_q[i] = pkt_q[i];
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        send_pkt(8'h00, 8'hEF, 8'h02, 8'hED);
        idle(50);
        check("plan_y239", bus.ball_y_rx, 239);
        bus.uart_rx = 1'b0;
        repeat (5) @(negedge clk_25MHZ);
        idle(40);
        send_frame(8'h5A);
        send_byte(SYNC);
        send_byte(8'h01);
        model_timeout();
        idle(TMO + 60);
        send_good(10'd777, 8'h81);
        idle(50);

        send_good(10'd300, 8'hFD);
        idle(20);
        send_byte(SYNC);
        send_byte(8'h01);
        pkt_q.delete();
        m_y = '0;
        m_vy = '0;
        send_raw(8'h2C, 1'b1, 4);
        send_byte(8'hFD);
        send_byte(8'hD0);
        idle(50);
        check("post_rst_y", bus.ball_y_rx, 0);
        check("post_rst_vy", bus.ball_vy_rx, 0);
        send_good(10'd512, 8'h7F);
        idle(50);

        for (int t = 0; t < 30; t++) begin
            ry = 10'($urandom_range(0, 1023));
            rv = 8'($urandom);
            case ($urandom_range(0, 5))
                0, 1: send_good(ry, rv);
                2: begin
                    rh = {6'd0, ry[9:8]};
                    send_pkt(rh, ry[7:0], rv, rh ^ ry[7:0] ^ rv ^ 8'($urandom_range(1, 255)));
                end
                3: send_pkt(8'($urandom_range(4, 255)), ry[7:0], rv, 8'($urandom));
                4: for (int k = 0; k < 3; k++) send_byte(8'($urandom));
                default: begin
                    if ($urandom_range(0, 1) == 0) send_frame(rv);
                    else begin
                        send_byte(SYNC);
                        send_byte({6'd0, ry[9:8]});
                        model_timeout();
                        idle(TMO + 60);
                    end
                end
            endcase
            idle($urandom_range(0, 150));
        end

        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk_25MHZ);
        check("sb_drain", sb.size(), 0);
        check("final_y", bus.ball_y_rx, m_y);
        check("final_vy", bus.ball_vy_rx, m_vy);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ball_link_rx.md
Name: ball_link_rx

Overview:
Receives ball-handoff packets sent by the opponent board over a single-wire UART link and presents the decoded ball state to the local game logic. It is the receive end of the board-to-board ball transfer: the peer board sends when its ball exits, and this block decodes the packet. It contains a 2-flop synchronizer, an 8N1 byte receiver and a packet parser with checksum and inter-byte timeout. Decoded values are held in registers and announced with a one-cycle valid strobe.

Parameters:
CLKS_PER_BIT, 217, system clocks per UART bit (25 MHz / 115200).
SYNC_BYTE, 8'hA5, packet header byte.
TIMEOUT_CLKS, 8680, maximum idle clocks between bytes inside a packet (about 4 byte times).

Ports:
clk_25MHZ  input  1  system clock
reset  input  1  asynchronous, active-high reset
uart_rx  input  1  serial line from the peer board, idle high
ball_rx_valid  output  1  one-cycle pulse when a good packet has been decoded
ball_y_rx  output  10  received ball Y position, held until the next good packet
ball_vy_rx  output  8  received signed Y velocity (two's complement), held
frame_err  output  1  one-cycle pulse when a stop bit is sampled low
pkt_err  output  1  one-cycle pulse on checksum mismatch, bad Y_HI, or timeout

Behaviour:
- Reset values: all outputs 0. Byte FSM = IDLE, parser = WAIT_SYNC. Synchronizer flops reset to 1.
- Packet format, 5 bytes, each LSB first, 8N1:
  - SYNC_BYTE
  - Y_HI: bits[1:0] = Y[9:8]; bits[7:2] must be 0
  - Y_LO = Y[7:0]
  - VY
  - CHK = Y_HI ^ Y_LO ^ VY
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE: synchronized rx = 0 -> START, counter cleared.
  - START: at count CLKS_PER_BIT/2 (108), resample. Low -> DATA. High -> false start, back to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT clocks at mid-bit, shifting right into bit 7. After 8 bits -> STOP.
  - STOP: sample at mid-bit. High -> byte_strobe for 1 cycle. Low -> frame_err pulse, byte discarded, parser forced to WAIT_SYNC.
  - After STOP, return to IDLE immediately; the second half of the stop bit is not waited for.
- Parser states: WAIT_SYNC, GET_YHI, GET_YLO, GET_VY, GET_CHK.
  - WAIT_SYNC: advances only on a byte equal to SYNC_BYTE; any other byte is ignored silently.
  - Each subsequent byte advances one state.
  - GET_YHI with bits[7:2] != 0: pkt_err pulse, -> WAIT_SYNC.
  - GET_CHK with matching checksum: latch ball_y_rx and ball_vy_rx, pulse ball_rx_valid, -> WAIT_SYNC.
  - GET_CHK with mismatch: pkt_err pulse, outputs unchanged, -> WAIT_SYNC.
- Latency: ball_rx_valid and the new output values appear in the same cycle, exactly one clock after the internal byte_strobe of the CHK byte. The outputs are registered.
- Timeout: in any parser state other than WAIT_SYNC, an idle counter runs while no byte_strobe occurs and clears on each strobe. Reaching TIMEOUT_CLKS gives a pkt_err pulse and -> WAIT_SYNC.
  - A byte mid-reception does not reset the counter; only a completed byte does.
- A SYNC_BYTE value received in a non-WAIT_SYNC state is treated as data and does not resynchronize.
- Simultaneous events:
  - frame_err and pkt_err never pulse in the same cycle.
  - When a frame error occurs, frame_err takes priority and the timeout counter is cleared.
- Asynchronous reset mid-packet aborts everything. Held outputs return to 0. The first packet after reset release must start with a fresh start bit.
- Width rules:
  - ball_y_rx = {Y_HI[1:0], Y_LO}, unsigned.
  - ball_vy_rx is passed through bit-exact; the consumer sign-extends it.
  - Counters are sized from CLKS_PER_BIT and TIMEOUT_CLKS using $clog2.

Test Plan:
- Send A5 01 2C FD D0 at 217 clk/bit -> one ball_rx_valid pulse; ball_y_rx = 300, ball_vy_rx = 8'hFD (-3); no errors.
- Same packet with CHK = D1 -> pkt_err pulse one clock after the final byte; ball_rx_valid stays 0; previous outputs held.
- Noise bytes 00 FF 3C, then a good packet A5 00 EF 02 ED -> only the packet decodes: ball_y_rx = 239, ball_vy_rx = 2; no error pulses from the noise.
- 40-clock low glitch on uart_rx while idle -> no byte, no error. A byte with the stop bit forced low -> frame_err pulse; parser back to WAIT_SYNC.
- Send A5 01, then hold the line idle for 9000 clocks -> pkt_err once the counter reaches 8680 idle clocks. A following good packet decodes normally.
- Assert reset mid-way through Y_LO of a packet -> all outputs 0 immediately. The remaining bits produce no strobe or error. The next full packet decodes correctly.
